// File: rtl/tune_pkg.sv
// tune_pkg: shared types, tune identifiers and note tables for tune_player.
// Default note field widths match the tune_player parameter defaults.
package tune_pkg;

   localparam int NOTE_TUNE_W = 2;
   localparam int NOTE_IDX_W  = 4;
   localparam int NOTE_HP_W   = 17;
   localparam int NOTE_DUR_W  = 24;

   localparam logic [NOTE_TUNE_W-1:0] TUNE_WIN   = 2'd0;
   localparam logic [NOTE_TUNE_W-1:0] TUNE_DEATH = 2'd1;
   localparam logic [NOTE_TUNE_W-1:0] TUNE_HOP   = 2'd2;
   localparam logic [NOTE_TUNE_W-1:0] TUNE_LEVEL = 2'd3;

   // Silence inserted between notes when the gap option is built in.
   localparam int unsigned GAP_CYCLES = 65536;
   localparam int          GAP_W      = 17;

   // hp is the half period in clk cycles (0 = rest), dur the note length.
   typedef struct packed {
      logic [NOTE_HP_W-1:0]  hp;
      logic [NOTE_DUR_W-1:0] dur;
      logic                  last;
   } note_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   function automatic note_t mk_note(input int hp, input int dur, input logic last);
      note_t n;
      n.hp   = NOTE_HP_W'(hp);
      n.dur  = NOTE_DUR_W'(dur);
      n.last = last;
      return n;
   endfunction

   // Table lookup. Entries past a tune's last note read as a terminating rest.
   // LEVEL deliberately carries no last flag: it ends on index wrap.
   function automatic note_t tune_lookup(input logic [NOTE_TUNE_W-1:0] tune,
                                         input logic [NOTE_IDX_W-1:0]  idx);
      note_t n;
      n = mk_note(0, 0, 1'b1);
      case (tune)
         TUNE_WIN: begin
            case (idx)
               4'd0:    n = mk_note(4474, 3125000, 1'b0);
               4'd1:    n = mk_note(3986, 3125000, 1'b0);
               4'd2:    n = mk_note(3551, 6250000, 1'b1);
               default: ;
            endcase
         end
         TUNE_DEATH: begin
            case (idx)
               4'd0:    n = mk_note(1000, 2000000, 1'b0);
               4'd1:    n = mk_note(0,    1000000, 1'b0);
               4'd2:    n = mk_note(1500, 4000000, 1'b1);
               default: ;
            endcase
         end
         TUNE_HOP: begin
            case (idx)
               4'd0:    n = mk_note(100, 1024000, 1'b0);
               4'd1:    n = mk_note(0,   512000,  1'b0);
               4'd2:    n = mk_note(50,  0,       1'b1);
               default: ;
            endcase
         end
         default: n = mk_note(3000 - 150 * int'(idx), 102400, 1'b0);
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tune_rom.sv
// tune_rom: combinational (tune, idx) -> note lookup into the package tables.
module tune_rom
   import tune_pkg::*;
(
   input  logic [NOTE_TUNE_W-1:0] tune,
   input  logic [NOTE_IDX_W-1:0]  idx,
   output note_t                  note
);

   // Pure table decode; the player registers the result on load.
   always_comb begin
      note = tune_lookup(tune, idx);
   end

endmodule

// File: rtl/tune_player.sv
// tune_player: table-driven square-wave sequencer with selectable tunes,
// rests, preemption on a new start edge, mute and busy/done status.
// Optional macro TUNE_PLAYER_GAP_EN inserts a silent gap between notes.
module tune_player
   import tune_pkg::*;
#(
   parameter int TUNE_W    = NOTE_TUNE_W,
   parameter int IDX_W     = NOTE_IDX_W,
   parameter int HP_W      = NOTE_HP_W,
   parameter int DUR_W     = NOTE_DUR_W,
   parameter int DUR_SHIFT = 0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TUNE_W-1:0] tune_sel,
   input  logic              mute,
   output logic              sound_out,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  note_idx
);

   state_e            state_q, state_d;
   logic              start_q, start_d;
   logic [TUNE_W-1:0] tune_q, tune_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   note_t             note_q, note_d;
   logic [HP_W-1:0]   ph_cnt_q, ph_cnt_d;
   logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
   logic              tone_q, tone_d;
   logic              done_c;

   logic              trig;
   logic              load;
   logic              dur_term;
   logic              is_last;
   logic [DUR_W-1:0]  dur_sh, dur_eff;
   logic [TUNE_W-1:0] rom_tune;
   logic [IDX_W-1:0]  rom_idx;
   note_t             rom_note;

`ifdef TUNE_PLAYER_GAP_EN
   localparam int unsigned        GAP_SH   = GAP_CYCLES >> DUR_SHIFT;
   localparam int unsigned        GAP_EFF  = (GAP_SH == 0) ? 1 : GAP_SH;
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_EFF - 1);
   logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
`endif

   assign trig     = start & ~start_q;
   // On a trigger the ROM is pointed at note 0 of the new tune, otherwise
   // at the successor of the current note so it is ready at note end.
   assign rom_tune = trig ? tune_sel : tune_q;
   assign rom_idx  = trig ? '0 : idx_q + 1'b1;

   tune_rom u_rom (
      .tune (rom_tune),
      .idx  (rom_idx),
      .note (rom_note)
   );

   // Effective note length: shifted for fast simulation, never below one cycle.
   always_comb begin
      dur_sh   = note_q.dur >> DUR_SHIFT;
      dur_eff  = (dur_sh == '0) ? DUR_W'(1) : dur_sh;
      dur_term = (dur_cnt_q == dur_eff - 1'b1);
      // An unflagged entry at the top index still ends the tune.
      is_last  = note_q.last | (&idx_q);
   end

   // Sequencer next-state: trigger/preempt, tone phase, note advance, gap.
   always_comb begin
      state_d   = state_q;
      start_d   = start;
      tune_d    = tune_q;
      idx_d     = idx_q;
      note_d    = note_q;
      ph_cnt_d  = ph_cnt_q;
      dur_cnt_d = dur_cnt_q;
      tone_d    = tone_q;
      done_c    = 1'b0;
      load      = 1'b0;
`ifdef TUNE_PLAYER_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      if (trig) begin
         // A new edge always wins, including over a finishing last note.
         tune_d = tune_sel;
         idx_d  = '0;
         load   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_PLAY: begin
               if (dur_term) begin
                  if (is_last) begin
                     done_c    = 1'b1;
                     state_d   = ST_IDLE;
                     idx_d     = '0;
                     tone_d    = 1'b0;
                     ph_cnt_d  = '0;
                     dur_cnt_d = '0;
                  end else begin
`ifdef TUNE_PLAYER_GAP_EN
                     state_d   = ST_GAP;
                     gap_cnt_d = '0;
                     tone_d    = 1'b0;
                     ph_cnt_d  = '0;
                     dur_cnt_d = '0;
`else
                     idx_d = idx_q + 1'b1;
                     load  = 1'b1;
`endif
                  end
               end else begin
                  dur_cnt_d = dur_cnt_q + 1'b1;
                  if (note_q.hp == '0) begin
                     tone_d = 1'b0;
                  end else if (ph_cnt_q == note_q.hp - 1'b1) begin
                     ph_cnt_d = '0;
                     tone_d   = ~tone_q;
                  end else begin
                     ph_cnt_d = ph_cnt_q + 1'b1;
                  end
               end
            end
`ifdef TUNE_PLAYER_GAP_EN
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  idx_d = idx_q + 1'b1;
                  load  = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
      // Every note starts at phase high with fresh counters.
      if (load) begin
         state_d   = ST_PLAY;
         note_d    = rom_note;
         ph_cnt_d  = '0;
         dur_cnt_d = '0;
         tone_d    = (rom_note.hp != '0);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         tune_q    <= '0;
         idx_q     <= '0;
         note_q    <= '0;
         ph_cnt_q  <= '0;
         dur_cnt_q <= '0;
         tone_q    <= 1'b0;
`ifdef TUNE_PLAYER_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         tune_q    <= tune_d;
         idx_q     <= idx_d;
         note_q    <= note_d;
         ph_cnt_q  <= ph_cnt_d;
         dur_cnt_q <= dur_cnt_d;
         tone_q    <= tone_d;
`ifdef TUNE_PLAYER_GAP_EN
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   // Mute only gates the pin; sequencing carries on underneath.
   assign sound_out = tone_q & ~mute;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_c;
   assign note_idx  = idx_q;

endmodule

// File: tb/tb_tune_player.sv
// tb_tune_player: scoreboard bench for tune_player with DUR_SHIFT=10.
// Expected note_idx changes and done pulses are queued when a start is
// driven and consumed by a monitor sampling on the falling clock edge.
`timescale 1ns/1ps
module tb_tune_player;
   import tune_pkg::*;

`ifdef TUNE_PLAYER_GAP_EN
   localparam int G = 64;
`else
   localparam int G = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       mute = 1'b0;
   logic [1:0] tune_sel = TUNE_WIN;
   logic       sound_out, busy, done;
   logic [3:0] note_idx;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   logic [3:0] idx_prev = 4'd0;

   typedef struct { int c; int v; } ev_t;
   ev_t exp_idx_q[$];
   int  exp_done_q[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tune_player #(.DUR_SHIFT(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .tune_sel  (tune_sel),
      .mute      (mute),
      .sound_out (sound_out),
      .busy      (busy),
      .done      (done),
      .note_idx  (note_idx)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to 1ns after the edge that begins cycle c.
   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_idx(input int c, input int v);
      ev_t e;
      e.c = c;
      e.v = v;
      exp_idx_q.push_back(e);
   endtask

   // Full WIN tune started in cycle n.
   task automatic push_win(input int n);
      push_idx(n + 3052 + G, 1);
      push_idx(n + 6103 + 2*G, 2);
      exp_done_q.push_back(n + 12205 + 2*G);
      push_idx(n + 12206 + 2*G, 0);
   endtask

   // Full HOP tune started in cycle n.
   task automatic push_hop(input int n);
      push_idx(n + 1001 + G, 1);
      push_idx(n + 1501 + 2*G, 2);
      exp_done_q.push_back(n + 1501 + 2*G);
      push_idx(n + 1502 + 2*G, 0);
   endtask

   // Monitor: every done pulse and note_idx change must match the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         if (done === 1'b1) begin
            if (exp_done_q.size() == 0) chk("done_unexpected_cycle", cyc, 0);
            else chk("done_cycle", cyc, exp_done_q.pop_front());
         end
         if (note_idx !== idx_prev) begin
            if (exp_idx_q.size() == 0) chk("idx_unexpected_cycle", cyc, 0);
            else begin
               e = exp_idx_q.pop_front();
               chk("idx_cycle", cyc, e.c);
               chk("idx_value", note_idx, e.v);
            end
         end
      end
      idx_prev <= note_idx;
   end

   initial begin
      int n, r, p, d, t2;

      // Reset state
      go(3);
      chk("rst_busy", busy, 0);
      chk("rst_sound", sound_out, 0);
      chk("rst_done", done, 0);
      chk("rst_idx", note_idx, 0);
      go(4);
      reset = 1'b0;
      mon_en = 1'b1;

      // WIN, reset during note 2: no done, outputs cleared next cycle
      n = 10;
      go(n);
      tune_sel = TUNE_WIN;
      start = 1'b1;
      push_idx(n + 3052 + G, 1);
      push_idx(n + 6103 + 2*G, 2);
      go(n + 1);
      chk("a_busy", busy, 1);
      chk("a_sound", sound_out, 1);
      go(n + 5);
      start = 1'b0;
      r = n + 6103 + 2*G + 100;
      go(r);
      reset = 1'b1;
      push_idx(r + 1, 0);
      go(r + 1);
      reset = 1'b0;
      chk("a_rst_busy", busy, 0);
      chk("a_rst_sound", sound_out, 0);
      chk("a_rst_done", done, 0);

      // Full WIN replay from note 0
      n = r + 5;
      go(n);
      start = 1'b1;
      push_win(n);
      go(n + 1);
      chk("b_busy", busy, 1);
      chk("b_sound", sound_out, 1);
      go(n + 3);
      start = 1'b0;
      go(n + 3051);
      chk("b_n0_end_sound", sound_out, 1);
      go(n + 3052 + 10);
      chk("b_gap_or_n1_sound", sound_out, (G > 0) ? 0 : 1);
      t2 = n + 6103 + 2*G;
      go(t2);
      chk("b_n2_start_sound", sound_out, 1);
      go(t2 + 3550);
      chk("b_n2_pre_toggle", sound_out, 1);
      go(t2 + 3551);
      chk("b_n2_toggle", sound_out, 0);
      go(n + 12205 + 2*G);
      chk("b_busy_last", busy, 1);
      go(n + 12206 + 2*G);
      chk("b_busy_end", busy, 0);
      chk("b_sound_end", sound_out, 0);

      // Mute for whole tune with start held 20000 cycles
      n = cyc + 5;
      go(n);
      mute = 1'b1;
      start = 1'b1;
      push_win(n);
      go(n + 1);
      chk("c_busy", busy, 1);
      for (int c = n + 1; c <= n + 12206 + 2*G; c += 97) begin
         go(c);
         chk("c_mute_sound", sound_out, 0);
      end
      go(n + 12206 + 2*G);
      chk("c_busy_end", busy, 0);
      go(n + 20000);
      start = 1'b0;
      mute = 1'b0;

      // Preempt WIN during note 1 with DEATH
      n = cyc + 5;
      go(n);
      tune_sel = TUNE_WIN;
      start = 1'b1;
      push_idx(n + 3052 + G, 1);
      go(n + 3);
      start = 1'b0;
      p = n + 3052 + G + 500;
      go(p);
      tune_sel = TUNE_DEATH;
      start = 1'b1;
      push_idx(p + 1, 0);
      push_idx(p + 1954 + G, 1);
      push_idx(p + 2930 + 2*G, 2);
      exp_done_q.push_back(p + 6835 + 2*G);
      push_idx(p + 6836 + 2*G, 0);
      go(p + 1);
      chk("d_busy", busy, 1);
      chk("d_sound", sound_out, 1);
      go(p + 3);
      start = 1'b0;
      go(p + 1000);
      chk("d_pre_toggle", sound_out, 1);
      go(p + 1001);
      chk("d_toggle", sound_out, 0);
      go(p + 1954 + G + 5);
      chk("d_rest_sound", sound_out, 0);
      go(p + 6836 + 2*G);
      chk("d_busy_end", busy, 0);

      // HOP: short half period, rest, floored duration; restart on last note
      n = cyc + 5;
      go(n);
      tune_sel = TUNE_HOP;
      start = 1'b1;
      push_idx(n + 1001 + G, 1);
      push_idx(n + 1501 + 2*G, 2);
      go(n + 1);
      chk("e_sound0", sound_out, 1);
      go(n + 3);
      start = 1'b0;
      go(n + 100);
      chk("e_pre_toggle", sound_out, 1);
      go(n + 101);
      chk("e_toggle", sound_out, 0);
      go(n + 201);
      chk("e_toggle2", sound_out, 1);
      go(n + 1001 + G + 10);
      chk("e_rest_sound", sound_out, 0);
      d = n + 1501 + 2*G;
      go(d);
      start = 1'b1;
      chk("e_last_sound", sound_out, 1);
      push_idx(d + 1, 0);
      push_hop(d);
      go(d + 1);
      chk("e_restart_busy", busy, 1);
      chk("e_restart_sound", sound_out, 1);
      go(d + 3);
      start = 1'b0;
      go(d + 1502 + 2*G);
      chk("e_busy_end", busy, 0);

      // LEVEL: no last flag, ends at index wrap
      n = cyc + 5;
      go(n);
      tune_sel = TUNE_LEVEL;
      start = 1'b1;
      for (int k = 1; k < 16; k++) push_idx(n + 1 + 100*k + k*G, k);
      exp_done_q.push_back(n + 1600 + 15*G);
      push_idx(n + 1601 + 15*G, 0);
      go(n + 3);
      start = 1'b0;
      go(n + 1600 + 15*G);
      chk("f_busy_last", busy, 1);
      go(n + 1601 + 15*G);
      chk("f_busy_end", busy, 0);

      go(cyc + 20);
      chk("sb_idx_left", exp_idx_q.size(), 0);
      chk("sb_done_left", exp_done_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
